// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: valid/ready front end for an 8-point FFT core.
// Gathers 8 samples, loads and runs the core, then streams out 8 bins.
//
// Ports:
//   CLK, RST                   clock, async active-high reset
//   s_valid/s_ready/s_real/s_imag   sample input stream
//   fft_write, fft_start       load strobe and compute enable to the core
//   fft_in_real/fft_in_imag    packed frame to the core, slot k at [k*DW +: DW]
//   fft_ready                  core results valid
//   fft_out_real/fft_out_imag  packed core results, bin k at [k*DW +: DW]
//   m_valid/m_ready/m_real/m_imag/m_index/m_last   bin output stream
//   busy, err, frame_cnt       status: activity, sticky timeout, frames done
//
// Build option: define FFT_SEQ_PINGPONG_EN for two input frame buffers,
// letting the next frame fill while the current one is processed.
module fft_frame_sequencer #(
    parameter int DW          = 16,
    parameter int FFT_LATENCY = 2,
    parameter int TIMEOUT     = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_real,
    input  logic [DW-1:0]   s_imag,
    output logic            fft_write,
    output logic            fft_start,
    output logic [8*DW-1:0] fft_in_real,
    output logic [8*DW-1:0] fft_in_imag,
    input  logic            fft_ready,
    input  logic [8*DW-1:0] fft_out_real,
    input  logic [8*DW-1:0] fft_out_imag,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_real,
    output logic [DW-1:0]   m_imag,
    output logic [2:0]      m_index,
    output logic            m_last,
    output logic            busy,
    output logic            err,
    output logic [15:0]     frame_cnt
);

    localparam int LW = (FFT_LATENCY > 2) ? $clog2(FFT_LATENCY) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FILL,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic [2:0]      r_in_cnt;
    logic [2:0]      r_out_cnt;
    logic [LW-1:0]   r_lat_cnt;
    logic [TW-1:0]   r_wait_cnt;
    logic [DW-1:0]   r_res_re [8];
    logic [DW-1:0]   r_res_im [8];
    logic            r_err;
    logic [15:0]     r_frame_cnt;

    logic            w_s_fire;
    logic            w_m_fire;
    logic            w_lat_done;

`ifdef FFT_SEQ_PINGPONG_EN
    logic [8*DW-1:0] r_buf_re [2];
    logic [8*DW-1:0] r_buf_im [2];
    logic            r_wr_sel;
    logic            r_rd_sel;
    logic [1:0]      r_full;

    // Input side only stalls when the buffer it would fill is still owned
    // by the processing side, i.e. both buffers hold unprocessed frames.
    assign s_ready     = ~RST & ~r_full[r_wr_sel];
    assign fft_in_real = r_buf_re[r_rd_sel];
    assign fft_in_imag = r_buf_im[r_rd_sel];
`else
    logic [8*DW-1:0] r_buf_re;
    logic [8*DW-1:0] r_buf_im;

    assign s_ready     = ~RST & (r_state == S_FILL);
    assign fft_in_real = r_buf_re;
    assign fft_in_imag = r_buf_im;
`endif

    assign w_s_fire   = s_valid & s_ready;
    assign w_m_fire   = m_valid & m_ready;
    assign w_lat_done = (r_lat_cnt == LW'(FFT_LATENCY - 1));

    assign fft_write  = (r_state == S_LOAD);
    assign fft_start  = (r_state == S_RUN);
    assign m_valid    = (r_state == S_DRAIN);
    assign m_real     = r_res_re[r_out_cnt];
    assign m_imag     = r_res_im[r_out_cnt];
    assign m_index    = r_out_cnt;
    assign m_last     = (r_state == S_DRAIN) && (r_out_cnt == 3'd7);
    assign busy       = (r_state != S_FILL) || (r_in_cnt != 3'd0);
    assign err        = r_err;
    assign frame_cnt  = r_frame_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_FILL;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_lat_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
            for (int k = 0; k < 8; k++) begin
                r_res_re[k] <= '0;
                r_res_im[k] <= '0;
            end
`ifdef FFT_SEQ_PINGPONG_EN
            r_buf_re[0] <= '0;
            r_buf_re[1] <= '0;
            r_buf_im[0] <= '0;
            r_buf_im[1] <= '0;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_full      <= '0;
`else
            r_buf_re    <= '0;
            r_buf_im    <= '0;
`endif
        end else begin
`ifdef FFT_SEQ_PINGPONG_EN
            // Fill side runs independently of the processing FSM.
            if (w_s_fire) begin
                r_buf_re[r_wr_sel][int'(r_in_cnt)*DW +: DW] <= s_real;
                r_buf_im[r_wr_sel][int'(r_in_cnt)*DW +: DW] <= s_imag;
                r_in_cnt <= r_in_cnt + 3'd1;
                if (r_in_cnt == 3'd7) begin
                    r_full[r_wr_sel] <= 1'b1;
                    r_wr_sel         <= ~r_wr_sel;
                end
            end
`endif
            unique case (r_state)
                S_FILL: begin
`ifdef FFT_SEQ_PINGPONG_EN
                    if (r_full[r_rd_sel]) begin
                        r_state <= S_LOAD;
                    end
`else
                    if (w_s_fire) begin
                        r_buf_re[int'(r_in_cnt)*DW +: DW] <= s_real;
                        r_buf_im[int'(r_in_cnt)*DW +: DW] <= s_imag;
                        r_in_cnt <= r_in_cnt + 3'd1;
                        if (r_in_cnt == 3'd7) begin
                            r_state <= S_LOAD;
                        end
                    end
`endif
                end
                S_LOAD: begin
                    r_lat_cnt  <= '0;
                    r_wait_cnt <= '0;
                    r_state    <= S_RUN;
                end
                S_RUN: begin
                    // Latency phase first, then the bounded wait for ready.
                    if (!w_lat_done) begin
                        r_lat_cnt <= r_lat_cnt + LW'(1);
                    end else if (fft_ready) begin
                        r_state <= S_CAPTURE;
                    end else if (r_wait_cnt == TW'(TIMEOUT)) begin
                        r_err   <= 1'b1;
                        r_state <= S_FILL;
`ifdef FFT_SEQ_PINGPONG_EN
                        r_full[r_rd_sel] <= 1'b0;
                        r_rd_sel         <= ~r_rd_sel;
`endif
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                S_CAPTURE: begin
                    for (int k = 0; k < 8; k++) begin
                        r_res_re[k] <= fft_out_real[k*DW +: DW];
                        r_res_im[k] <= fft_out_imag[k*DW +: DW];
                    end
                    r_out_cnt <= '0;
                    r_state   <= S_DRAIN;
`ifdef FFT_SEQ_PINGPONG_EN
                    // Results are held locally now, so the input buffer
                    // can be handed back to the fill side.
                    r_full[r_rd_sel] <= 1'b0;
                    r_rd_sel         <= ~r_rd_sel;
`endif
                end
                S_DRAIN: begin
                    if (w_m_fire) begin
                        r_out_cnt <= r_out_cnt + 3'd1;
                        if (r_out_cnt == 3'd7) begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
`ifdef FFT_SEQ_PINGPONG_EN
                            r_state <= r_full[r_rd_sel] ? S_LOAD : S_FILL;
`else
                            r_state <= S_FILL;
`endif
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: self-checking bench for fft_frame_sequencer.
// Drives a stub FFT core and checks framing, timing, and bin order.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;

    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int TO  = 32;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_real = '0;
    logic [DW-1:0]   s_imag = '0;
    logic            fft_write;
    logic            fft_start;
    logic [8*DW-1:0] fft_in_real;
    logic [8*DW-1:0] fft_in_imag;
    logic            fft_ready = 1'b1;
    logic [8*DW-1:0] fft_out_real;
    logic [8*DW-1:0] fft_out_imag;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [DW-1:0]   m_real;
    logic [DW-1:0]   m_imag;
    logic [2:0]      m_index;
    logic            m_last;
    logic            busy;
    logic            err;
    logic [15:0]     frame_cnt;

    logic            stub_mode = 1'b0;

    always #5 CLK = ~CLK;

    fft_frame_sequencer #(
        .DW(DW), .FFT_LATENCY(LAT), .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag),
        .fft_write(fft_write), .fft_start(fft_start),
        .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
        .fft_ready(fft_ready),
        .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_real(m_real), .m_imag(m_imag),
        .m_index(m_index), .m_last(m_last),
        .busy(busy), .err(err), .frame_cnt(frame_cnt)
    );

    // Stub core: fixed bins (100+k, -k), or a data-dependent mapping
    // real[k] = in_real[7-k] + k, imag[k] = in_imag[k] ^ 5A5A.
    always_comb begin
        fft_out_real = '0;
        fft_out_imag = '0;
        for (int k = 0; k < 8; k++) begin
            if (stub_mode) begin
                fft_out_real[k*DW +: DW] = fft_in_real[(7-k)*DW +: DW] + DW'(k);
                fft_out_imag[k*DW +: DW] = fft_in_imag[k*DW +: DW] ^ 16'h5A5A;
            end else begin
                fft_out_real[k*DW +: DW] = DW'(100 + k);
                fft_out_imag[k*DW +: DW] = DW'(-k);
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drain vectors: m_ready to apply and the bin expected that cycle.
    typedef struct {
        logic          mr;
        logic [2:0]    idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } dvec_t;

    dvec_t vt [24];

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            m_ready = vt[i].mr;
            check("drain_valid", m_valid, 1'b1);
            check("drain_index", m_index, vt[i].idx);
            check("drain_real", m_real, vt[i].re);
            check("drain_imag", m_imag, vt[i].im);
            check("drain_last", m_last, vt[i].last);
            tick();
        end
        m_ready = 1'b0;
    endtask

    // Reference model state (active only during streamed phases).
    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [2:0]    idx;
    } bin_t;

    bit              mon_en = 0;
    bit              pp_chk = 0;
    int              in_n = 0;
    int              out_frames = 0;
    logic [8*DW-1:0] cur_re, cur_im, fr_re, fr_im;
    logic [8*DW-1:0] fq_re [$];
    logic [8*DW-1:0] fq_im [$];
    bin_t            bq [$];
    bin_t            eb;
    bit              prev_write = 0;
    bit              prev_stall = 0;
    logic [DW-1:0]   prev_re, prev_im;
    logic [2:0]      prev_idx;

    always @(negedge CLK) begin
        if (mon_en) begin
            if (s_valid && s_ready) begin
                cur_re[in_n*DW +: DW] = s_real;
                cur_im[in_n*DW +: DW] = s_imag;
                in_n++;
                if (in_n == 8) begin
                    fq_re.push_back(cur_re);
                    fq_im.push_back(cur_im);
                    in_n = 0;
                end
            end
            if (fft_write) begin
                check("write_single_cycle", prev_write, 1'b0);
                check("write_after_full_frame", fq_re.size() > 0, 1'b1);
                if (fq_re.size() > 0) begin
                    fr_re = fq_re.pop_front();
                    fr_im = fq_im.pop_front();
                    check("fft_in_real", fft_in_real, fr_re);
                    check("fft_in_imag", fft_in_imag, fr_im);
                    for (int k = 0; k < 8; k++) begin
                        eb.re  = fr_re[(7-k)*DW +: DW] + DW'(k);
                        eb.im  = fr_im[k*DW +: DW] ^ 16'h5A5A;
                        eb.idx = 3'(k);
                        bq.push_back(eb);
                    end
                end
            end
            prev_write = fft_write;
            if (prev_stall) begin
                check("hold_valid", m_valid, 1'b1);
                check("hold_real", m_real, prev_re);
                check("hold_imag", m_imag, prev_im);
                check("hold_index", m_index, prev_idx);
            end
            if (m_valid && m_ready) begin
                check("bin_expected", bq.size() > 0, 1'b1);
                if (bq.size() > 0) begin
                    eb = bq.pop_front();
                    check("out_real", m_real, eb.re);
                    check("out_imag", m_imag, eb.im);
                    check("out_index", m_index, eb.idx);
                    check("out_last", m_last, eb.idx == 3'd7);
                    if (eb.idx == 3'd7) out_frames++;
                end
            end
`ifdef FFT_SEQ_PINGPONG_EN
            if (pp_chk && m_valid && out_frames == 0)
                check("pp_s_ready_in_drain", s_ready, 1'b1);
`endif
            prev_stall = m_valid && !m_ready;
            prev_re    = m_real;
            prev_im    = m_imag;
            prev_idx   = m_index;
        end
    end

    task automatic run_stream(input int nf, input bit gap_first,
                              input bit rand_mr, input int fc0);
        bit done;
        done       = 0;
        out_frames = 0;
        in_n       = 0;
        fq_re.delete();
        fq_im.delete();
        bq.delete();
        prev_write = 0;
        prev_stall = 0;
        stub_mode  = 1'b1;
        fft_ready  = 1'b1;
        mon_en     = 1;
        fork
            begin
                for (int f = 0; f < nf; f++) begin
                    for (int k = 0; k < 8; k++) begin
                        if (gap_first && f == 0) begin
                            s_valid = 1'b0;
                            tick();
                            tick();
                        end
                        s_valid = 1'b1;
                        s_real  = DW'($urandom);
                        s_imag  = DW'($urandom);
                        for (int b = 0; b < 200 && !s_ready; b++) tick();
                        if (!s_ready) check("s_ready_wait", s_ready, 1'b1);
                        tick();
                    end
                end
                s_valid = 1'b0;
                done    = 1;
            end
            begin
                for (int c = 0; c < 5000; c++) begin
                    if (done && out_frames == nf) break;
                    m_ready = rand_mr ? ($urandom_range(0, 2) != 0) : 1'b1;
                    tick();
                end
                m_ready = 1'b0;
                check("stream_frames_out", out_frames, nf);
            end
        join
        mon_en = 0;
        check("stream_frame_cnt", frame_cnt, 16'(fc0 + nf));
        check("stream_inq_empty", fq_re.size(), 0);
        check("stream_binq_empty", bq.size(), 0);
    endtask

    task automatic feed_const_frame();
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1;
            s_real  = DW'(k);
            s_imag  = '0;
            check("fill_s_ready", s_ready, 1'b1);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_write();
        for (int b = 0; b < 10 && !fft_write; b++) tick();
        check("fft_write_seen", fft_write, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8*DW-1:0] exp_in;
        logic [3:0]      pat;
        int              acc;
        int              starts;

        // Vectors 0..7: free-flowing drain; 8..23: m_ready 1,0,0,1 pattern.
        for (int i = 0; i < 8; i++) begin
            vt[i].mr   = 1'b1;
            vt[i].idx  = 3'(i);
            vt[i].re   = DW'(100 + i);
            vt[i].im   = DW'(-i);
            vt[i].last = (i == 7);
        end
        pat = 4'b1001;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            vt[8+i].mr   = pat[i % 4];
            vt[8+i].idx  = 3'(acc);
            vt[8+i].re   = DW'(100 + acc);
            vt[8+i].im   = DW'(-acc);
            vt[8+i].last = (acc == 7);
            if (pat[i % 4]) acc++;
        end
        for (int k = 0; k < 8; k++) exp_in[k*DW +: DW] = DW'(k);

        // Reset state
        tick();
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_fft_write", fft_write, 1'b0);
        check("rst_fft_start", fft_start, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_real", m_real, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_frame_cnt", frame_cnt, '0);
        check("rst_fft_in", fft_in_real, '0);
        RST = 1'b0;
        tick();
        check("post_rst_s_ready", s_ready, 1'b1);

        // Single frame, samples (k,0), stub bins (100+k,-k)
        feed_const_frame();
        wait_write();
`ifndef FFT_SEQ_PINGPONG_EN
        check("load_s_ready", s_ready, 1'b0);
`endif
        check("load_fft_in_real", fft_in_real, exp_in);
        check("load_fft_in_imag", fft_in_imag, '0);
        check("load_busy", busy, 1'b1);
        tick();
        check("write_one_cycle", fft_write, 1'b0);
        starts = 0;
        while (fft_start && starts < 100) begin
            starts++;
            tick();
        end
        check("start_cycles", starts, LAT);
        check("capture_m_valid", m_valid, 1'b0);
        check("capture_fft_in", fft_in_real, exp_in);
        tick();
        apply_vecs(0, 8);
        check("f1_m_valid_done", m_valid, 1'b0);
        check("f1_frame_cnt", frame_cnt, 16'd1);

        // Backpressure during drain
        feed_const_frame();
        wait_write();
        for (int b = 0; b < 20 && !m_valid; b++) tick();
        apply_vecs(8, 24);
        check("bp_m_valid_done", m_valid, 1'b0);
        check("bp_frame_cnt", frame_cnt, 16'd2);

        // Timeout: core never ready
        fft_ready = 1'b0;
        feed_const_frame();
        wait_write();
        tick();
        check("to_start_rise", fft_start, 1'b1);
        for (int n = 1; n <= LAT + TO; n++) begin
            tick();
            check("to_err_timing", err, n == LAT + TO);
            check("to_no_m_valid", m_valid, 1'b0);
        end
        check("to_start_low", fft_start, 1'b0);
        check("to_frame_cnt", frame_cnt, 16'd2);
        check("to_s_ready", s_ready, 1'b1);
        fft_ready = 1'b1;

        // Next frame after timeout, gapped input (1 valid in 3 cycles)
        run_stream(1, 1, 1, 2);
        check("err_sticky", err, 1'b1);

        // Randomised data, random backpressure
        run_stream(4, 0, 1, 3);

        // Continuous input and output for three frames
        pp_chk = 1;
        run_stream(3, 0, 0, 7);
        pp_chk = 0;

        // Reset mid-drain after bin 3
        stub_mode = 1'b0;
        feed_const_frame();
        wait_write();
        for (int b = 0; b < 20 && !m_valid; b++) tick();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        m_ready = 1'b0;
        check("mid_drain_index", m_index, 3'd4);
        #2;
        RST = 1'b1;
        #1;
        check("mrst_m_valid", m_valid, 1'b0);
        check("mrst_fft_start", fft_start, 1'b0);
        check("mrst_err", err, 1'b0);
        check("mrst_frame_cnt", frame_cnt, '0);
        check("mrst_s_ready", s_ready, 1'b0);
        check("mrst_busy", busy, 1'b0);
        tick();
        RST = 1'b0;
        tick();
        check("mrst_s_ready_after", s_ready, 1'b1);
        check("mrst_m_valid_after", m_valid, 1'b0);
        run_stream(1, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Front-end controller for the 8-point FFT core.
- Collects a stream of complex samples into 8-sample frames, loads each frame into the core (write), runs the core (start) and waits for completion (ready).
- Captures the 8 bins and streams them out in order.
- Provides the valid/ready framing that the core lacks, plus a timeout and an error flag.

Parameters:
- DW, 16, sample component width (two's complement), real and imag each.
- FFT_LATENCY, 2, cycles fft_start is held before results are sampled; must be >= 2.
- TIMEOUT, 32, max cycles to wait for fft_ready after FFT_LATENCY expires.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  asynchronous active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  sequencer can accept a sample.
- s_real  in  DW  input sample real part.
- s_imag  in  DW  input sample imag part.
- fft_write  out  1  load strobe to the core.
- fft_start  out  1  compute enable to the core.
- fft_in_real  out  8*DW  packed frame real parts; sample k at bits [k*DW +: DW].
- fft_in_imag  out  8*DW  packed frame imag parts, same packing.
- fft_ready  in  1  core results valid.
- fft_out_real  in  8*DW  packed core result real parts, bin k at [k*DW +: DW].
- fft_out_imag  in  8*DW  packed core result imag parts.
- m_valid  out  1  output bin valid.
- m_ready  in  1  downstream accepts the bin.
- m_real  out  DW  output bin real part.
- m_imag  out  DW  output bin imag part.
- m_index  out  3  bin number 0..7.
- m_last  out  1  high with bin 7.
- busy  out  1  state != FILL, or in_cnt != 0.
- err  out  1  sticky timeout flag; cleared only by RST.
- frame_cnt  out  16  completed frames, wraps at 65535 -> 0.

Behaviour:
- Reset: all outputs 0 (s_ready 0 only while RST is high), state FILL, counters 0, frame buffers 0.
- FILL:
  - s_ready = 1; sample accepted when s_valid & s_ready and written to slot in_cnt, then in_cnt++.
  - On acceptance of slot 7 -> LOAD, in_cnt -> 0.
- LOAD: fft_write = 1 for exactly one cycle; fft_in_* hold the frame buffer stable from LOAD through CAPTURE; -> RUN.
- RUN:
  - fft_start = 1 and lat_cnt counts up.
  - When lat_cnt == FFT_LATENCY-1 and fft_ready = 1 -> CAPTURE.
  - If fft_ready = 0 at that point, keep fft_start high and count wait_cnt.
  - When wait_cnt == TIMEOUT -> set err, drop the frame, return to FILL (no output, frame_cnt unchanged).
- CAPTURE: fft_start = 0; register all 16 fft_out_* words into the result buffer in one cycle; -> DRAIN.
- DRAIN:
  - m_valid = 1; m_real/m_imag/m_index present bin out_cnt.
  - On m_valid & m_ready, out_cnt++.
  - Bin 7 accepted -> frame_cnt++, -> FILL.
  - Outputs hold stable while m_ready = 0 (no bubbles, no drops).
- s_ready = 0 in LOAD/RUN/CAPTURE/DRAIN.
- No arithmetic beyond counters; data passes unmodified, width DW.
- RST asserted mid-frame: immediate return to reset state; partial input and output are discarded.

Optional Feature:
- Macro FFT_SEQ_PINGPONG_EN.
- Defined:
  - Two input frame buffers; FILL of buffer B proceeds while buffer A is in LOAD/RUN/CAPTURE/DRAIN, so s_ready stays 1 except when both buffers are full.
  - LOAD of the next frame is issued the cycle after bin 7 of the previous frame is accepted.
- Undefined: single buffer, strictly serial FILL->LOAD->RUN->CAPTURE->DRAIN as above.

Test Plan:
- Single frame: feed samples (k,0) for k=0..7 with a stub core returning bin k = (100+k, -k), fft_ready high -> one fft_write pulse; fft_start high 2 cycles; m outputs (100..107, 0..-7) with index 0..7, m_last on 7; frame_cnt = 1.
- Backpressure: m_ready toggled 1,0,0,1 during DRAIN -> each bin held stable while m_ready = 0, all 8 delivered once in order.
- Timeout: stub holds fft_ready = 0 -> err = 1 exactly FFT_LATENCY+TIMEOUT cycles after fft_start rises; no m_valid; frame_cnt = 0; next frame with ready = 1 completes normally and err stays 1.
- Reset mid-DRAIN after bin 3: assert RST -> m_valid, fft_start, err, frame_cnt = 0 immediately; s_ready = 1 the cycle after RST falls.
- Gapped input: s_valid asserted 1 of every 3 cycles -> LOAD only after the 8th accepted sample; fft_in_real slot order matches input order.
- FFT_SEQ_PINGPONG_EN: continuous s_valid for 3 frames with m_ready = 1 -> s_ready never low during the first frame's DRAIN; frame_cnt = 3; output order is frame 0, then 1, then 2.
